wide_add_sequencer: RTL
=======================

WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the adder slice width in bits.
REQ-002 The block SHALL have parameter WORDS, default 4, giving the slices per operand; operand width W = N*WORDS.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 sub  input  1  operation select: 0 = A+B, 1 = A-B; sampled with start.
REQ-007 a  input  W  operand A, two's complement; sampled with start.
REQ-008 b  input  W  operand B, two's complement; sampled with start.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse; result outputs valid.
REQ-011 sum  output  W  result register.
REQ-012 cout  output  1  carry out of bit W-1; for sub, 1 = no borrow.
REQ-013 overflow  output  1  signed overflow of the W-bit operation.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ADD, DONE.
REQ-015 IDLE -> ADD on a rising edge with start=1: latch a, b (B' = sub ? ~b : b) and sub; clear slice index to 0; set carry register to sub.
REQ-016 start SHALL be ignored in ADD and DONE; a, b, sub changes after the accepting edge SHALL NOT affect the result.
REQ-017 Each ADD edge SHALL compute one N-bit slice: {c, s} = A[idx] + B'[idx] + carry; write s into sum[idx*N +: N]; carry <= c; idx <= idx+1.
REQ-018 Slices SHALL be processed LSB first, one per cycle; no combinational carry path SHALL span more than one N-bit slice.
REQ-019 The edge processing slice WORDS-1 SHALL set cout to the final carry and overflow = (A[W-1] == B'[W-1]) && (s[N-1] != A[W-1]), and transition ADD -> DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, then go to IDLE unconditionally.
REQ-021 Latency: start sampled at edge 0; done high in the cycle between edge WORDS and edge WORDS+1; minimum start-to-start period WORDS+2 cycles.
REQ-022 sum, cout and overflow SHALL hold their values from DONE through IDLE until the next accepted start; during ADD, sum contents are intermediate and only valid when done=1 or afterwards.
REQ-023 The result SHALL equal (a + (sub ? ~b + 1 : b)) mod 2^W for every input pair, including the wrap-around cases a=2^W-1, b=1 and a=0, b=1 with sub=1.
REQ-024 The slice index SHALL be wide enough for WORDS and SHALL NOT wrap within an operation; WORDS=1 SHALL work with a single ADD cycle.

Reset
REQ-025 On rst_n=0, the block SHALL immediately, without waiting for clk, set state to IDLE and clear busy, done, sum, cout, overflow, carry, index and latched operands to 0.
REQ-026 Reset asserted during ADD or DONE SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Verification (N=32, WORDS=4, W=128)
REQ-027 a=2^128-1, b=1, sub=0, start for one cycle -> done high exactly 4 edges after the accepting edge; sum=0, cout=1, overflow=0.
REQ-028 a=0x7FFF...F, b=1, sub=0 -> sum=0x8000...0, cout=0, overflow=1; a=0x8000...0, b=0x8000...0 -> sum=0, cout=1, overflow=1.
REQ-029 a=5, b=7, sub=1 -> sum=0xFFFF...FFFE, cout=0, overflow=0; a=7, b=5, sub=1 -> sum=2, cout=1, overflow=0.
REQ-030 start pulsed again during ADD, and a/b changed to random values after the accepting edge -> no second operation; result matches the latched operands; busy stays high for 5 cycles.
REQ-031 rst_n pulsed low mid-cycle after the second ADD edge -> all outputs 0 immediately and no done pulse; a new start (a=1, b=2) -> sum=3 with normal latency.
REQ-032 start held high continuously with random operands -> done pulses every 6 cycles, and every result matches the reference model of REQ-023.

Source files
------------

// File: rtl/wide_add_sequencer_if.sv
// rtl/wide_add_sequencer_if.sv - operand/result bundle for the slice-serial wide adder
interface wide_add_sequencer_if #(
  parameter int N     = 32,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - W-bit add/subtract computed one N-bit slice per clock, LSB first
module wide_add_sequencer #(
  parameter int N     = 32,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wide_add_sequencer_if.slave   bus
);
  localparam int            W    = N * WORDS;
  localparam int            IW   = $clog2(WORDS + 1);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry;
  logic [IW-1:0] idx;
  logic [W-1:0]  sum_q;
  logic          cout_q;
  logic          ovf_q;
  logic          busy_q;
  logic          done_q;

  logic [N-1:0]  a_sl;
  logic [N-1:0]  b_sl;
  logic [N-1:0]  s;
  logic          c;

  // Carry chain is confined to one slice; the inter-slice carry goes through a register.
  always_comb begin
    a_sl   = a_q[idx*N +: N];
    b_sl   = b_q[idx*N +: N];
    {c, s} = {1'b0, a_sl} + {1'b0, b_sl} + {{N{1'b0}}, carry};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
            a_q    <= bus.a;
            b_q    <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          sum_q[idx*N +: N] <= s;
          carry             <= c;
          idx               <= idx + IW'(1);
          if (idx == LAST) begin
            cout_q <= c;
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (s[N-1] != a_q[W-1]);
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule
